tt_vector_checker: RTL and testbench

- Synthesizable truth-table sequencer and checker for small combinational DUTs, for example a 4-input AND gate.
- Steps through every 2^N_IN input combination, holds each for a settle window, samples the DUT output and compares it against a parameterised expected truth table.
- Reports an error count, the first failing vector and a pass/fail verdict.
- Lets on-board labs self-check a gate without a simulator testbench.

---
 rtl/tt_vector_checker.sv | 130 +++++++++++++
 tb/tb_tt_vector_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tt_vector_checker.sv
// rtl/tt_vector_checker.sv - truth-table sequencer/checker for a small combinational DUT
// Optional macro TT_CHECK_STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module tt_vector_checker #(
  parameter int N_IN = 4,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'h8000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ffv_q, ffv_d;
  logic            ffvalid_q, ffvalid_d;
  logic            mismatch;
  logic            stop_on_fail;

`ifdef TT_CHECK_STOP_ON_FAIL_EN
  assign stop_on_fail = 1'b1;
`else
  assign stop_on_fail = 1'b0;
`endif

  // dut_f only matters while sampling; outside SAMPLE the mismatch term is ignored
  assign mismatch = (dut_f != EXPECTED[vec_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
      S_DRIVE:        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if ((mismatch && stop_on_fail) || (vec_q == VEC_LAST)) state_d = S_DONE;
        else state_d = S_DRIVE;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d     = '0;
          cnt_d     = '0;
          pass_d    = 1'b0;
          err_d     = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
        end
      end
      S_DRIVE: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!ffvalid_q) begin
            ffv_d     = vec_q;
            ffvalid_d = 1'b1;
          end
        end
        // the verdict folds in the current sample, so it uses err_d, not err_q
        if ((mismatch && stop_on_fail) || (vec_q == VEC_LAST)) begin
          pass_d = (err_d == '0);
        end else begin
          vec_d = vec_q + N_IN'(1);
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy             = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
    done             = (state_q == S_DONE);
    vec_out          = vec_q;
    pass             = pass_q;
    err_count        = err_q;
    first_fail_vec   = ffv_q;
    first_fail_valid = ffvalid_q;
  end

endmodule

// File: tb/tb_tt_vector_checker.sv
// tb/tb_tt_vector_checker.sv - scoreboard bench for tt_vector_checker
module tb_tt_vector_checker;

  localparam int N_IN = 4;
  localparam int NV = 1 << N_IN;
  localparam int SETTLE = 2;
  localparam logic [NV-1:0] EXP_TT = 16'h8000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [N_IN-1:0] vec_out;
  logic            dut_f;
  logic            busy, done, pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_vec;
  logic            first_fail_valid;

  logic [NV-1:0]   actual_tt = EXP_TT;
  int              cyc = 0;
  int              passed = 0;
  int              total = 0;

  typedef struct {
    int k;
    int done_cyc;
    int err;
    int ffv;
    bit ffvalid;
    bit pass;
    int vend;
  } exp_t;

  exp_t sb[$];

  tt_vector_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .EXPECTED(EXP_TT)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_out(vec_out), .dut_f(dut_f),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
  );

  // the simulated gate under test is just a lookup into the chosen truth table
  assign dut_f = actual_tt[vec_out];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [NV-1:0] tt, input int k);
    exp_t e;
    int len;
    e.k = k; e.err = 0; e.ffv = 0; e.ffvalid = 0; e.vend = NV - 1;
    len = NV;
    for (int i = 0; i < NV; i++) begin
      if (tt[i] != EXP_TT[i]) begin
        e.err++;
        if (!e.ffvalid) begin
          e.ffvalid = 1;
          e.ffv = i;
        end
`ifdef TT_CHECK_STOP_ON_FAIL_EN
        len = i + 1;
        e.vend = i;
        break;
`endif
      end
    end
    e.pass = (e.err == 0);
    e.done_cyc = k + len * (SETTLE + 1);
    return e;
  endfunction

  // monitor: per-cycle vector stepping while busy, full verdict when done rises
  initial begin
    logic done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && busy && !reset)
        chk("vec_step", int'(vec_out), (cyc - sb[0].k) / (SETTLE + 1));
      if (done && !done_prev && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("err_count", int'(err_count), e.err);
        chk("first_fail_vec", int'(first_fail_vec), e.ffv);
        chk("first_fail_valid", int'(first_fail_valid), int'(e.ffvalid));
        chk("pass", int'(pass), int'(e.pass));
        chk("vec_end", int'(vec_out), e.vend);
        chk("busy_at_done", int'(busy), 0);
      end
      done_prev = done;
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic run(input logic [NV-1:0] tt, input int extra_at);
    int k;
    @(negedge clk);
    actual_tt = tt;
    start = 1'b1;
    k = cyc + 1;
    sb.push_back(model(tt, k));
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_start", int'(busy), 1);
    chk("cleared_err", int'(err_count), 0);
    chk("cleared_ffvalid", int'(first_fail_valid), 0);
    if (extra_at > 0) begin
      while (cyc < k + extra_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_vec", int'(vec_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_ffv", int'(first_fail_vec), 0);
    chk("rst_ffvalid", int'(first_fail_valid), 0);

    run(EXP_TT, 0);
    run(16'h0000, 0);
    run(16'hFFFF, 0);
    run(EXP_TT, 10);
    run(16'hFFFF, 0);

    begin : mid_run_reset
      int k;
      @(negedge clk);
      actual_tt = EXP_TT;
      start = 1'b1;
      k = cyc + 1;
      sb.push_back(model(EXP_TT, k));
      @(negedge clk);
      start = 1'b0;
      while (cyc < k + 19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      chk("mid_rst_vec", int'(vec_out), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_err", int'(err_count), 0);
    end
    run(EXP_TT, 0);

    for (int r = 0; r < 6; r++) begin
      logic [NV-1:0] tt;
      tt = ($urandom_range(0, 3) == 0) ? EXP_TT : (EXP_TT ^ NV'($urandom));
      run(tt, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
